alu_byte_host: RTL and testbench
================================

Name: alu_byte_host

Overview:
- Host-side master for the byte-serial FP32 add/sub ALU port: start, 8-bit operand bus, 1-bit opcode, done, 8-bit result bus.
- Accepts a 32-bit A/B/op request over a valid/ready handshake, then pulses start to the ALU.
- Streams A then B to the ALU LSB-first, captures the four result bytes qualified by the ALU's done, and returns a 32-bit result over a valid/ready response handshake.
- Includes a watchdog that reports an error if the ALU's done never arrives.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT before aborting with resp_err=1 (must be >=3)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  host request valid
req_ready  output  1  block can accept a request
req_a  input  32  operand A (FP32 bits)
req_b  input  32  operand B (FP32 bits)
req_sub  input  1  0=A+B, 1=A-B
resp_valid  output  1  response available
resp_ready  input  1  host accepts response
resp_result  output  32  assembled result
resp_err  output  1  1 = watchdog expired, result invalid (0)
alu_start  output  1  start to ALU
alu_opcode  output  1  opcode to ALU
alu_in  output  8  operand byte to ALU
alu_done  input  1  done from ALU
alu_out  input  8  result byte from ALU

Behaviour:
- Reset (rst=1 at edge): state=IDLE; req_ready=1; resp_valid=0; resp_result=0; resp_err=0; alu_start=0; alu_opcode=0; alu_in=0; counters=0.
  - Reset mid-operation aborts immediately and discards latched data.
  - Does not reset the ALU; the integrator must reset both together.
- All outputs are driven from registers or state decode only; there is no combinational path from req_* or resp_ready to any output.
- States:
  - IDLE: req_ready=1. On an edge with req_valid=1, latch A, B and sub, then go to START. req_ready=0 in every other state.
  - START (1 cycle): alu_start=1, alu_in=0. Go to SEND with byte counter=0.
  - SEND (8 cycles): alu_start=0.
    - alu_in = A[8k+7:8k] for k=cnt in 0..3; B[8(k-4)+7:8(k-4)] for cnt in 4..7.
    - Counter increments per edge; at cnt=7 go to WAIT with watchdog=0.
  - WAIT:
    - Edge with alu_done=1: capture alu_out into result[7:0], go to RECV with cnt=1.
    - Otherwise watchdog increments. When it reaches TIMEOUT-1 with done still low: result=0, err=1, go to RESP.
  - RECV: each edge captures alu_out into result byte cnt (1,2,3). After cnt=3, go to RESP with err=0.
    - alu_done is not rechecked in RECV; the ALU holds done high for exactly 4 consecutive cycles.
  - RESP: resp_valid=1, with resp_result and resp_err stable. On an edge with resp_ready=1, go to IDLE. resp_valid is held indefinitely under backpressure.
- alu_opcode equals latched sub from START through RECV, is 0 in IDLE, and must not change during the ALU's execute cycle.
- Nominal timing, with T0 = edge accepting the request:
  - START T0–T1.
  - Bytes sampled by the ALU at T2..T9.
  - ALU executes at T10 and asserts done at T11.
  - Captures at T12..T15.
  - resp_valid=1 after T15, i.e. 15 cycles after acceptance.
  - Nominal WAIT dwell is 3 edges; TIMEOUT=16 gives margin.
- Back-to-back operation: a new request is accepted in the IDLE cycle right after the resp handshake. START then coincides with the ALU's IDLE cycle that clears done, which is legal.
- After a timeout the ALU state is undefined. The host must reset before the next request; a request issued without that reset is unsupported.

Test Plan:
- Add: A=0x3F800000 (1.0), B=0x40000000 (2.0), sub=0 against the real ALU -> alu_in sequence 00,00,80,3F,00,00,00,40; resp_result=0x40400000, resp_err=0; resp_valid rises exactly 15 cycles after acceptance.
- Subtract: A=0x40A00000 (5.0), B=0x3FC00000 (1.5), sub=1 -> alu_opcode=1 from START to RESP; resp_result=0x40600000.
- Backpressure then back-to-back: hold resp_ready=0 for 10 cycles -> resp_valid and result stable, req_ready=0. Release, then issue 1.0+1.0 in the next IDLE cycle -> 0x40000000.
- Watchdog: ALU model never asserts done, TIMEOUT=16 -> resp_valid with resp_err=1 and resp_result=0 after 16 WAIT cycles.
- Reset mid-SEND (rst=1 at cnt=4) -> next cycle all outputs at reset values and req_ready=1; a subsequent 1.0+2.0 (both blocks reset) returns 0x40400000.
- Byte capture order: ALU model emits done with bytes 11,22,33,44 -> resp_result=0x44332211.

Source files
------------

// File: rtl/alu_byte_host.sv
// Host-side master for a byte-serial FP32 add/sub ALU.
// Takes a 32-bit A/B/op request, pulses start, streams A then B LSB-first,
// collects four result bytes framed by the ALU's done, and returns the
// assembled word (or a watchdog error) over a valid/ready response.
module alu_byte_host #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_sub,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_err,
    output logic        alu_start,
    output logic        alu_opcode,
    output logic [7:0]  alu_in,
    input  logic        alu_done,
    input  logic [7:0]  alu_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_RESP
    } state_e;

    localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic            sub_q, sub_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [31:0]     result_q, result_d;
    logic            err_q, err_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic            alu_start_q, alu_start_d;
    logic            alu_opcode_q, alu_opcode_d;
    logic [7:0]      alu_in_q, alu_in_d;

    // Byte k of the 64-bit {B, A} stream: k=0..3 walks A, k=4..7 walks B.
    function automatic logic [7:0] stream_byte(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [2:0]  k);
        logic [63:0] ab;
        ab = {b, a};
        return ab[{k, 3'b000} +: 8];
    endfunction

    // Next-state, datapath and next-output logic; outputs are registered
    // from the *next* state so they line up with the state they describe.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        cnt_d    = cnt_q;
        wd_d     = wd_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    sub_d   = req_sub;
                    err_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = 3'd0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (cnt_q == 3'd7) begin
                    wd_d    = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WAIT: begin
                if (alu_done) begin
                    result_d[7:0] = alu_out;
                    cnt_d         = 3'd1;
                    state_d       = S_RECV;
                end else if (wd_q == WD_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RECV: begin
                // The ALU holds done for exactly four cycles, so bytes 1..3
                // are taken on consecutive edges without re-checking done.
                result_d[{cnt_q[1:0], 3'b000} +: 8] = alu_out;
                if (cnt_q == 3'd3) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        alu_start_d  = (state_d == S_START);
        // Opcode is held from START until the response is taken, so it can
        // never move while the ALU is executing.
        alu_opcode_d = (state_d != S_IDLE) ? sub_d : 1'b0;
        alu_in_d     = (state_d == S_SEND) ? stream_byte(a_d, b_d, cnt_d) : 8'h00;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sub_q        <= 1'b0;
            cnt_q        <= '0;
            wd_q         <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            alu_start_q  <= 1'b0;
            alu_opcode_q <= 1'b0;
            alu_in_q     <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sub_q        <= sub_d;
            cnt_q        <= cnt_d;
            wd_q         <= wd_d;
            result_q     <= result_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            alu_start_q  <= alu_start_d;
            alu_opcode_q <= alu_opcode_d;
            alu_in_q     <= alu_in_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = result_q;
    assign resp_err    = err_q;
    assign alu_start   = alu_start_q;
    assign alu_opcode  = alu_opcode_q;
    assign alu_in      = alu_in_q;

endmodule

// File: tb/tb_alu_byte_host.sv
// Directed bench for alu_byte_host with a cycle-accurate byte-serial ALU model.
module tb_alu_byte_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_sub;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        resp_err;
    logic        alu_start;
    logic        alu_opcode;
    logic [7:0]  alu_in;
    logic        alu_done;
    logic [7:0]  alu_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_byte_host #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_sub     (req_sub),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .alu_start   (alu_start),
        .alu_opcode  (alu_opcode),
        .alu_in      (alu_in),
        .alu_done    (alu_done),
        .alu_out     (alu_out)
    );

    // ---------------- ALU model ----------------
    // start seen at T1, bytes sampled T2..T9, execute T10, done+byte0 after
    // T11, bytes 1..3 after T12..T14, done drops after T15.
    logic        model_nodone = 1'b0;
    logic        model_force  = 1'b0;
    int          mcnt;
    logic [63:0] in_log;
    logic [31:0] mres;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
        if (!op && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if ( op && a == 32'h40A00000 && b == 32'h3FC00000) return 32'h40600000;
        if (!op && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        return 32'hDEADBEEF;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mcnt     <= 0;
            alu_done <= 1'b0;
            alu_out  <= 8'h00;
        end else if (alu_start) begin
            mcnt   <= 1;
            in_log <= '0;
        end else if (mcnt >= 1 && mcnt <= 8) begin
            in_log[(mcnt-1)*8 +: 8] <= alu_in;
            mcnt <= mcnt + 1;
        end else if (mcnt == 9) begin
            mres <= model_force ? 32'h44332211 : alu_fn(in_log[31:0], in_log[63:32], alu_opcode);
            mcnt <= 10;
        end else if (mcnt == 10) begin
            alu_done <= !model_nodone;
            alu_out  <= mres[7:0];
            mcnt     <= 11;
        end else if (mcnt >= 11 && mcnt <= 13) begin
            alu_out <= mres[(mcnt-10)*8 +: 8];
            mcnt    <= mcnt + 1;
        end else if (mcnt == 14) begin
            alu_done <= 1'b0;
            alu_out  <= 8'h00;
            mcnt     <= 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request; returns once the accepting edge has passed.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("req_ready_timeout", 64'(req_ready), 64'd1);
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Count edges from acceptance to resp_valid; tally opcode deviations.
    task automatic wait_resp(input logic sub, output int lat, output int op_bad);
        lat    = 0;
        op_bad = (alu_opcode !== sub) ? 1 : 0;
        while (lat < 100) begin
            tick();
            lat++;
            if (alu_opcode !== sub) op_bad++;
            if (resp_valid) break;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"},   64'(req_ready),   64'd1);
        check({pfx, "_resp_valid"},  64'(resp_valid),  64'd0);
        check({pfx, "_resp_result"}, 64'(resp_result), 64'd0);
        check({pfx, "_resp_err"},    64'(resp_err),    64'd0);
        check({pfx, "_alu_start"},   64'(alu_start),   64'd0);
        check({pfx, "_alu_opcode"},  64'(alu_opcode),  64'd0);
        check({pfx, "_alu_in"},      64'(alu_in),      64'd0);
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int op_bad;
        int bad;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_sub    = 1'b0;
        resp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("rst");

        // 1.0 + 2.0: byte stream, latency, result
        issue(32'h3F800000, 32'h40000000, 1'b0);
        wait_resp(1'b0, lat, op_bad);
        check("add_bytes",   in_log,             64'h40000000_3F800000);
        check("add_latency", 64'(lat),           64'd15);
        check("add_result",  64'(resp_result),   64'h40400000);
        check("add_err",     64'(resp_err),      64'd0);
        check("add_opcode",  64'(op_bad),        64'd0);
        take_resp();
        check("add_idle_ready", 64'(req_ready), 64'd1);

        // 5.0 - 1.5: opcode held high from START to RESP
        issue(32'h40A00000, 32'h3FC00000, 1'b1);
        wait_resp(1'b1, lat, op_bad);
        check("sub_opcode",  64'(op_bad),      64'd0);
        check("sub_latency", 64'(lat),         64'd15);
        check("sub_result",  64'(resp_result), 64'h40600000);
        check("sub_err",     64'(resp_err),    64'd0);

        // Backpressure for 10 cycles: response stays put, no new request taken
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (resp_valid !== 1'b1 || resp_result !== 32'h40600000 ||
                resp_err !== 1'b0 || req_ready !== 1'b0) bad++;
        end
        check("bp_stable", 64'(bad), 64'd0);

        // Release, then 1.0 + 1.0 in the very next IDLE cycle
        take_resp();
        check("b2b_ready", 64'(req_ready), 64'd1);
        issue(32'h3F800000, 32'h3F800000, 1'b0);
        wait_resp(1'b0, lat, op_bad);
        check("b2b_latency", 64'(lat),         64'd15);
        check("b2b_result",  64'(resp_result), 64'h40000000);
        take_resp();

        // Byte capture order
        model_force = 1'b1;
        issue(32'h01020304, 32'h05060708, 1'b0);
        wait_resp(1'b0, lat, op_bad);
        check("order_result", 64'(resp_result), 64'h44332211);
        take_resp();
        model_force = 1'b0;

        // Reset in the middle of SEND (cnt=4), then a clean 1.0 + 2.0
        issue(32'h3F800000, 32'h40000000, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("mid_send_byte", 64'(alu_in), 64'h00);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        issue(32'h3F800000, 32'h40000000, 1'b0);
        wait_resp(1'b0, lat, op_bad);
        check("post_rst_result", 64'(resp_result), 64'h40400000);
        check("post_rst_err",    64'(resp_err),    64'd0);
        take_resp();

        // Watchdog: done never comes -> error after 16 WAIT cycles
        model_nodone = 1'b1;
        issue(32'h3F800000, 32'h40000000, 1'b0);
        wait_resp(1'b0, lat, op_bad);
        check("wd_latency", 64'(lat),         64'd25);
        check("wd_valid",   64'(resp_valid),  64'd1);
        check("wd_err",     64'(resp_err),    64'd1);
        check("wd_result",  64'(resp_result), 64'd0);
        take_resp();
        check("wd_idle_ready", 64'(req_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
